uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, legal 5..9: payload width per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2: number of queued words.
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cfg_div, input, DIV_WIDTH: bit period = cfg_div+1 clk cycles.
REQ-007 SHALL have port cfg_parity, input, 2: 00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port cfg_stop2, input, 1: 0 gives one stop bit, 1 gives two.
REQ-009 SHALL have port wr_en, input, 1: write request.
REQ-010 SHALL have port wr_data, input, DATA_BITS: word to enqueue.
REQ-011 SHALL have port clr_ovf, input, 1: clears the overflow flag.
REQ-012 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH words.
REQ-013 SHALL have port empty, output, 1: FIFO holds 0 words.
REQ-014 SHALL have port level, output, $clog2(FIFO_DEPTH)+1: current word count.
REQ-015 SHALL have port overflow, output, 1: sticky; a write was attempted while full.
REQ-016 SHALL have port tx_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-017 SHALL have port uart_s_out, output, 1: registered serial line; idles high.

Function
REQ-018 A write SHALL be accepted when wr_en=1 and full=0; level, empty and full update on the next cycle.
REQ-019 When full=1, a write SHALL be dropped regardless of a same-cycle pop, and overflow SHALL set on the next cycle.
REQ-020 When clr_ovf=1, overflow SHALL clear on the next cycle; a same-cycle dropped write takes priority and keeps overflow set.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-022 In IDLE with empty=0, the FSM SHALL pop one word and latch the word, cfg_div, cfg_parity and cfg_stop2 into frame registers; config changes during a frame SHALL NOT take effect.
REQ-023 Frame order: start bit 0, then DATA_BITS bits LSB first, then a parity bit if enabled, then 1 or 2 stop bits at 1.
REQ-024 Parity SHALL be XOR of the data bits for even and its inverse for odd.
REQ-025 Each bit SHALL hold uart_s_out for exactly cfg_div+1 cycles, timed by a DIV_WIDTH counter that reloads at each bit boundary; cfg_div=0 gives 1 cycle per bit.
REQ-026 Latency: a word written at cycle N into an empty FIFO with the FSM in IDLE SHALL drive the start bit on uart_s_out from cycle N+2.
REQ-027 In the last cycle of the final stop bit, the FSM SHALL pop and go to START if empty=0, else go to IDLE; back-to-back frames SHALL have no idle gap.
REQ-028 Frame length SHALL be (1+DATA_BITS+P+S)*(cfg_div+1) cycles, with P in {0,1} and S in {1,2}.
REQ-029 A simultaneous accepted write and pop SHALL leave level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst=1: uart_s_out=1, tx_busy=0, empty=1, full=0, level=0, overflow=0, FSM=IDLE, pointers and counters 0.
REQ-031 Reset mid-frame SHALL abort the frame and force uart_s_out high on the next cycle, discarding queued words; FIFO storage SHALL NOT be reset.

Structure
REQ-032 The shared package SHALL hold the parity-mode enum and the FSM state enum typedefs.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH) providing push, pop, full, empty and level.

Verification
REQ-034 Reset, cfg_div=3, 8N1, write 0x55 -> start bit from 2 cycles after the write; line 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; 40-cycle frame; tx_busy low afterwards.
REQ-035 Even parity, write 0x07 -> parity bit 1; odd parity, write 0x07 -> parity bit 0; cfg_stop2=1 -> two stop bits, 12-bit frame.
REQ-036 Write 3 words back-to-back with cfg_div=0 -> 30 contiguous frame cycles, no idle high between frames, level reaches 0.
REQ-037 FIFO_DEPTH=4, cfg_div=100, write 6 words -> full=1 after 5 words (1 popped, 4 queued); 6th write sets overflow; clr_ovf clears it.
REQ-038 Assert rst in the middle of the DATA state -> uart_s_out=1, tx_busy=0, level=0 on the next cycle; a new write then transmits correctly.
REQ-039 Change cfg_div from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_pkg
// Purpose : Shared types for the buffered UART transmitter: the parity-mode
//           encoding seen on cfg_parity and the transmit FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

    // Both 00 and 11 mean "no parity bit".
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic parity_enabled(input parity_e m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

endpackage : uart_tx_fifo_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with asynchronous (combinational) read port so
//           the head word is visible in the same cycle it is popped.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           push, wdata   - enqueue request and word (ignored when full)
//           pop, rdata    - dequeue request (ignored when empty), head word
//           full, empty   - occupancy flags
//           level         - current word count, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : UART transmitter fed by a word FIFO. Each frame latches its word
//           and line configuration when popped, so config edits only affect
//           later frames.
// Ports   : clk, rst               - clock, synchronous active-high reset
//           cfg_div                - bit period minus one, in clk cycles
//           cfg_parity, cfg_stop2  - parity mode, two-stop-bit select
//           wr_en, wr_data         - FIFO write
//           clr_ovf                - clear sticky overflow
//           full, empty, level     - FIFO status
//           overflow               - sticky: write attempted while full
//           tx_busy                - FSM not idle
//           uart_s_out             - registered serial line, idles high
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        clr_ovf,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        tx_busy,
    output logic                        uart_s_out
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_e              r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [DIV_WIDTH-1:0]   r_div, w_div_nxt;
    logic [BIT_W-1:0]       r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_par_en, w_par_en_nxt;
    logic                   r_par_bit, w_par_bit_nxt;
    logic                   r_stop2, w_stop2_nxt;
    logic                   r_s_out, w_line_nxt;
    logic                   r_ovf;
    logic                   w_bit_end;
    logic                   w_load;
    logic                   w_push;
    logic                   w_full, w_empty;
    logic [DATA_BITS-1:0]   w_rdata;
    parity_e                w_mode;

    assign w_mode     = parity_e'(cfg_parity);
    assign w_push     = wr_en && !w_full;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_ovf;
    assign tx_busy    = (r_state != ST_IDLE);
    assign uart_s_out = r_s_out;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (wr_data),
        .pop   (w_load),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // Next-state logic. The line value is derived from the *next* state so
    // the registered output changes in the same edge as the state does.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_stop2_nxt   = r_stop2;
        w_load        = 1'b0;
        w_bit_end     = (r_cnt == '0);

        case (r_state)
            ST_IDLE: w_load = !w_empty;
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = r_div;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = r_div;
                    if (r_bit == C_LAST_BIT) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = r_div;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && (r_bit == '0)) begin
                        w_bit_nxt = BIT_W'(1);
                        w_cnt_nxt = r_div;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Pop the head word and snapshot the line configuration for a frame.
        if (w_load) begin
            w_state_nxt   = ST_START;
            w_cnt_nxt     = cfg_div;
            w_div_nxt     = cfg_div;
            w_bit_nxt     = '0;
            w_shift_nxt   = w_rdata;
            w_par_en_nxt  = parity_enabled(w_mode);
            w_par_bit_nxt = (^w_rdata) ^ (w_mode == PAR_ODD);
            w_stop2_nxt   = cfg_stop2;
        end

        case (w_state_nxt)
            ST_START:  w_line_nxt = 1'b0;
            ST_DATA:   w_line_nxt = w_shift_nxt[0];
            ST_PARITY: w_line_nxt = w_par_bit_nxt;
            default:   w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_s_out   <= 1'b1;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_stop2   <= w_stop2_nxt;
            r_s_out   <= w_line_nxt;
            // A dropped write outranks a same-cycle clear.
            if (wr_en && w_full) r_ovf <= 1'b1;
            else if (clr_ovf)    r_ovf <= 1'b0;
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire
